dco_period_meter: RTL
=====================

Name: dco_period_meter

Overview:
Measures the toggle interval of a DCO output in system-clock cycles and converts it back to the 8-bit DCO control code that produces that interval. It is the decode direction of the DCO's code-to-period path. It is used for loop-back self-test and closed-loop calibration of the oscillator. It sits on the same clock as the DCO and samples the oscillator pin through a synchronizer.

Parameters:
CNT_W, 8, width of the interval counter and of the interval output
AVG_LOG2, 2, number of intervals averaged per result is 2^AVG_LOG2 (0..4)
TIMEOUT, 255, cycles without an edge before a measurement aborts; must be ≤ 2^CNT_W-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  1  block enable; low aborts any measurement
start  in  1  single-cycle request to begin a measurement
cont  in  1  continuous mode; when high, re-arm automatically after each result
osc_in  in  1  oscillator signal under test (asynchronous to the meter)
busy  out  1  high while in ARM or MEASURE
meas_valid  out  1  one-cycle pulse when a result is presented
interval  out  CNT_W  averaged toggle interval in clk cycles
code_out  out  8  decoded DCO code
code_hit  out  1  interval matched a table entry
timeout  out  1  last result ended by timeout

Behaviour:
- Synchronization: osc_in passes through a 2-FF synchronizer, then a third register for edge detection. An "edge" is any transition, rising or falling. The fixed 3-cycle latency does not affect intervals.
- Interval: for edges detected at cycles t0 and t1, the interval is t1-t0. The counter loads 1 on an edge, increments each cycle and saturates at 2^CNT_W-1.
- The FSM has four states: IDLE, ARM, MEASURE, DONE.
  - IDLE: waits for start=1 with ena=1, then goes to ARM. start in any other state is ignored.
  - ARM: waits for the first edge, which starts the counter, then goes to MEASURE. If TIMEOUT cycles pass with no edge, goes to DONE with timeout.
  - MEASURE: on each edge, adds the captured interval to an accumulator of width CNT_W+AVG_LOG2 and increments an interval count. After the 2^AVG_LOG2-th edge, goes to DONE. If the counter reaches TIMEOUT before the next edge, goes to DONE with timeout.
  - DONE: lasts one cycle. Asserts meas_valid and updates the result outputs. Then goes to ARM if cont=1 and ena=1, otherwise to IDLE.
- Result on a normal completion:
  - interval = accumulator >> AVG_LOG2, truncated.
  - timeout = 0.
- Result on a timeout:
  - interval = all-ones, code_out = 0, code_hit = 0, timeout = 1.
- Decode table, exact match on interval:
  - 11 → 0x80; 10 → 0x40; 9 → 0x20; 8 → 0x10; 7 → 0x08; 6 → 0x04; 5 → 0x02; 4 → 0x01.
  - 51 → 0x00, the idle/default code.
  - All of these set code_hit=1. Any other value gives code_out=0x00 and code_hit=0.
  - The decode is registered and updates in DONE together with interval.
- Latency: meas_valid is asserted in the cycle after the synchronized edge that completes the last interval.
- Output holding: interval, code_out, code_hit and timeout hold between results. meas_valid is a single-cycle pulse.
- ena=0 in any state: go to IDLE at the next edge, clear the accumulator and count, and do not assert meas_valid. Result outputs keep their last values.
- busy = 1 exactly in ARM and MEASURE.
- Simultaneous events:
  - An edge and a timeout in the same cycle: the edge wins.
  - rst with anything else: rst wins.
- Reset: synchronous and active-high, and it may be asserted mid-measurement. It clears the FSM to IDLE, the synchronizer and edge registers, the counter, the accumulator and the count. Output reset values: busy=0, meas_valid=0, interval=0, code_out=0, code_hit=0, timeout=0.
- No combinational path from osc_in to any output.

Test Plan:
1. osc_in toggles every 11 cycles, start pulse → one arming edge plus 4 intervals, then a meas_valid pulse with interval=11, code_out=0x80, code_hit=1, timeout=0. busy falls in the same cycle meas_valid rises.
2. Toggle every 4 cycles, then every 51 cycles (two runs) → run 1 gives code_out=0x01, code_hit=1. Run 2 gives interval=51, code_out=0x00, code_hit=1.
3. Intervals of 6,6,7,7 → sum 26 >> 2 gives interval=6, code_out=0x04, code_hit=1. An interval pattern averaging 13 gives code_out=0x00, code_hit=0.
4. osc_in held constant after start → after 255 cycles with no edge, meas_valid with timeout=1, interval=0xFF, code_hit=0. A stop mid-MEASURE also times out the same way.
5. cont=1 with toggle period 8 → back-to-back meas_valid pulses, each with interval=8 and code_out=0x10. A start pulse while busy has no effect. Dropping ena mid-MEASURE → IDLE with no meas_valid.
6. rst asserted for 1 cycle mid-MEASURE → next cycle all outputs are 0 and busy=0. A fresh start after that returns a correct result.

Source files
------------

// File: rtl/dco_period_meter.sv
// dco_period_meter
// Measures the toggle interval of a DCO output in clk cycles, averages
// 2^AVG_LOG2 consecutive intervals and decodes the average back to the
// 8-bit DCO control code that produces it.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   ena        block enable; low aborts any measurement
//   start      single-cycle request to begin a measurement (IDLE only)
//   cont       continuous mode; re-arm automatically after each result
//   osc_in     oscillator under test (asynchronous)
//   busy       high while in ARM or MEASURE
//   meas_valid one-cycle pulse when a result is presented
//   interval   averaged toggle interval in clk cycles
//   code_out   decoded DCO code
//   code_hit   interval matched a decode table entry
//   timeout    last result ended by timeout
module dco_period_meter #(
  parameter int CNT_W    = 8,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             cont,
  input  logic             osc_in,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] interval,
  output logic [7:0]       code_out,
  output logic             code_hit,
  output logic             timeout
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int NUM_W = AVG_LOG2 + 1;
  localparam logic [NUM_W-1:0] LAST_IDX = NUM_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic             sync_p0, sync_p1, sync_p2;
  logic             osc_edge;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [NUM_W-1:0] num;
  logic [ACC_W-1:0] sum_p2;
  logic             to_hit;
  logic             arm_entry;
  logic             load_res;
  logic [8:0]       dec_p2;
  logic [CNT_W-1:0] avg_p2;

  // Saturating increment so a stalled oscillator parks the counter at max.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Truncating average of the accumulated intervals.
  function automatic logic [CNT_W-1:0] avg_of(input logic [ACC_W-1:0] s);
    avg_of = CNT_W'(s >> AVG_LOG2);
  endfunction

  // Interval -> {hit, code}. 51 cycles is the idle/default code 0x00,
  // which is distinct from a miss only through the hit flag.
  function automatic logic [8:0] decode_code(input logic [CNT_W-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    case (w)
      32'd11:  decode_code = {1'b1, 8'h80};
      32'd10:  decode_code = {1'b1, 8'h40};
      32'd9:   decode_code = {1'b1, 8'h20};
      32'd8:   decode_code = {1'b1, 8'h10};
      32'd7:   decode_code = {1'b1, 8'h08};
      32'd6:   decode_code = {1'b1, 8'h04};
      32'd5:   decode_code = {1'b1, 8'h02};
      32'd4:   decode_code = {1'b1, 8'h01};
      32'd51:  decode_code = {1'b1, 8'h00};
      default: decode_code = {1'b0, 8'h00};
    endcase
  endfunction

  // ---- stage p0/p1: two-flop synchronizer; p2: edge-detect delay ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= osc_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign osc_edge = sync_p1 ^ sync_p2;

  // ---- stage p2: interval counter, accumulator, decode ----
  // The counter also restarts on ARM entry so that in ARM it measures the
  // time spent waiting for the arming edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (osc_edge || arm_entry) begin
      cnt <= CNT_W'(1);
    end else begin
      cnt <= sat_inc(cnt);
    end
  end

  assign sum_p2 = acc + ACC_W'(cnt);
  assign avg_p2 = avg_of(sum_p2);
  assign dec_p2 = decode_code(avg_p2);

  always_ff @(posedge clk) begin
    if (rst || !ena || arm_entry) begin
      acc <= '0;
      num <= '0;
    end else if (state == S_MEAS && osc_edge) begin
      acc <= sum_p2;
      num <= num + NUM_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; an edge takes priority over a timeout and a low
  // ena overrides every transition.
  always_comb begin
    next_state = state;
    to_hit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && ena) next_state = S_ARM;
      end
      S_ARM: begin
        if (osc_edge) begin
          next_state = S_MEAS;
        end else if (cnt >= TO_LIM) begin
          next_state = S_DONE;
          to_hit     = 1'b1;
        end
      end
      S_MEAS: begin
        if (osc_edge) begin
          if (num == LAST_IDX) next_state = S_DONE;
        end else if (cnt >= TO_LIM) begin
          next_state = S_DONE;
          to_hit     = 1'b1;
        end
      end
      S_DONE: begin
        next_state = (cont && ena) ? S_ARM : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (!ena) begin
      next_state = S_IDLE;
      to_hit     = 1'b0;
    end
  end

  assign arm_entry = (next_state == S_ARM) && (state != S_ARM);
  assign load_res  = (next_state == S_DONE);

  // FSM outputs
  always_comb begin
    busy       = (state == S_ARM) || (state == S_MEAS);
    meas_valid = (state == S_DONE);
  end

  // ---- stage p3: result registers, visible during DONE ----
  always_ff @(posedge clk) begin
    if (rst) begin
      interval <= '0;
      code_out <= 8'h00;
      code_hit <= 1'b0;
      timeout  <= 1'b0;
    end else if (load_res) begin
      if (to_hit) begin
        interval <= '1;
        code_out <= 8'h00;
        code_hit <= 1'b0;
        timeout  <= 1'b1;
      end else begin
        interval <= avg_p2;
        code_out <= dec_p2[7:0];
        code_hit <= dec_p2[8];
        timeout  <= 1'b0;
      end
    end
  end

endmodule
